// File: rtl/quad_decoder_pkg.sv
// Shared types and transition decode for the quadrature decoder.
// Gray order of {a,b} along the CW direction is 00 -> 10 -> 11 -> 01.
package quad_decoder_pkg;

  typedef logic [1:0] qstate_t;

  typedef enum logic [1:0] {NONE, CW, CCW, ERR} step_t;

  // Position of a state along the CW cycle (00=0, 10=1, 11=2, 01=3).
  function automatic logic [1:0] qidx(qstate_t s);
    return {s[0], s[1] ^ s[0]};
  endfunction

  // +1 along the cycle is CW, -1 is CCW, +2 means both phases moved at once.
  function automatic step_t qdecode(qstate_t prev, qstate_t cur);
    logic [1:0] d;
    d = qidx(cur) - qidx(prev);
    case (d)
      2'd1:    return CW;
      2'd2:    return ERR;
      2'd3:    return CCW;
      default: return NONE;
    endcase
  endfunction

endpackage

// File: rtl/quad_channel.sv
// One quadrature channel: 2-flop sync, stability filter, step decode, position counter.
// With QDEC_INDEX_EN defined, a synchronised rising edge on z clears the position like clr.
module quad_channel
  import quad_decoder_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int FILT_LEN = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  input  logic             clr,
`ifdef QDEC_INDEX_EN
  input  logic             z,
`endif
  output logic             cw,
  output logic             ccw,
  output logic             err,
  output logic             dir,
  output logic [CNT_W-1:0] pos
);

  localparam logic [3:0] FMAX = 4'(FILT_LEN);

  logic [1:0] sa, sb;
  qstate_t    sync, last, filt;
  logic [3:0] fcnt;
  logic       init, accept, clr_eff;
  step_t      st;

  assign sync = {sa[1], sb[1]};

  // last has been sampled FMAX times in a row; first acceptance only seeds filt.
  assign accept = (fcnt == FMAX) && (!init || (last != filt));

  always_comb begin
    st = NONE;
    if (accept && init) st = qdecode(filt, last);
  end

`ifdef QDEC_INDEX_EN
  logic [1:0] sz;
  logic       zprev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sz    <= '0;
      zprev <= 1'b0;
    end else begin
      sz    <= {sz[0], z};
      zprev <= sz[1];
    end
  end

  assign clr_eff = clr | (sz[1] & ~zprev);
`else
  assign clr_eff = clr;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa   <= '0;
      sb   <= '0;
      last <= '0;
      filt <= '0;
      fcnt <= '0;
      init <= 1'b0;
      cw   <= 1'b0;
      ccw  <= 1'b0;
      err  <= 1'b0;
      dir  <= 1'b0;
      pos  <= '0;
    end else begin
      sa <= {sa[0], a};
      sb <= {sb[0], b};

      if (sync != last) begin
        last <= sync;
        fcnt <= 4'd1;
      end else if (fcnt != FMAX) begin
        fcnt <= fcnt + 4'd1;
      end

      if (accept) begin
        filt <= last;
        init <= 1'b1;
      end

      cw  <= (st == CW);
      ccw <= (st == CCW);
      err <= (st == ERR);
      if (st == CW)  dir <= 1'b1;
      if (st == CCW) dir <= 1'b0;

      // Clear wins over a same-cycle step; the pulse and dir still go out.
      if (clr_eff)         pos <= '0;
      else if (st == CW)   pos <= pos + CNT_W'(1);
      else if (st == CCW)  pos <= pos - CNT_W'(1);
    end
  end

endmodule

// File: rtl/quad_decoder.sv
// NCH independent quadrature decoders; each lane is a quad_channel instance.
// Optional index input z is present only when QDEC_INDEX_EN is defined.
module quad_decoder
  import quad_decoder_pkg::*;
#(
  parameter int NCH      = 4,
  parameter int CNT_W    = 16,
  parameter int FILT_LEN = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NCH-1:0]            a,
  input  logic [NCH-1:0]            b,
  input  logic [NCH-1:0]            clr,
`ifdef QDEC_INDEX_EN
  input  logic [NCH-1:0]            z,
`endif
  output logic [NCH-1:0]            cw,
  output logic [NCH-1:0]            ccw,
  output logic [NCH-1:0]            err,
  output logic [NCH-1:0]            dir,
  output logic [NCH-1:0][CNT_W-1:0] pos
);

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    quad_channel #(
      .CNT_W    (CNT_W),
      .FILT_LEN (FILT_LEN)
    ) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .a     (a[gi]),
      .b     (b[gi]),
      .clr   (clr[gi]),
`ifdef QDEC_INDEX_EN
      .z     (z[gi]),
`endif
      .cw    (cw[gi]),
      .ccw   (ccw[gi]),
      .err   (err[gi]),
      .dir   (dir[gi]),
      .pos   (pos[gi])
    );
  end

endmodule

// File: tb/tb_quad_decoder.sv
// Scoreboard bench for quad_decoder (NCH=2, CNT_W=8, FILT_LEN=3).
// Stimulus pushes expected pulses; a negedge monitor pops and compares them.
module tb_quad_decoder;

  localparam int NCH      = 2;
  localparam int CNT_W    = 8;
  localparam int FILT_LEN = 3;
  localparam int LAT      = FILT_LEN + 3;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [NCH-1:0]            a, b, clr;
  logic [NCH-1:0]            cw, ccw, err, dir;
  logic [NCH-1:0][CNT_W-1:0] pos;
`ifdef QDEC_INDEX_EN
  logic [NCH-1:0]            z = '0;
`endif

  quad_decoder #(.NCH(NCH), .CNT_W(CNT_W), .FILT_LEN(FILT_LEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .clr   (clr),
`ifdef QDEC_INDEX_EN
    .z     (z),
`endif
    .cw    (cw),
    .ccw   (ccw),
    .err   (err),
    .dir   (dir),
    .pos   (pos)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int                        cyc;
    logic [NCH-1:0]            cw, ccw, err, dir;
    logic [NCH-1:0][CNT_W-1:0] pos;
  } exp_t;

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;

  logic [NCH-1:0][CNT_W-1:0] m_pos;
  logic [NCH-1:0]            m_dir;
  logic [NCH-1:0][1:0]       m_st;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // 1 = CW, 2 = CCW, 3 = illegal, 0 = no change
  function automatic int kind(input logic [1:0] p, input logic [1:0] n);
    case ({p, n})
      4'b0010, 4'b1011, 4'b1101, 4'b0100: return 1;
      4'b1000, 4'b1110, 4'b0111, 4'b0001: return 2;
      4'b0011, 4'b1100, 4'b0110, 4'b1001: return 3;
      default:                            return 0;
    endcase
  endfunction

  function automatic logic [1:0] cw_next(input logic [1:0] s);
    case (s)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  // Drive new {a,b} on both channels; optionally raise clr0 in the pulse cycle.
  task automatic apply(input logic [1:0] n0, input logic [1:0] n1, input bit clr_hit, input int hold);
    exp_t                e;
    logic [NCH-1:0][1:0] nn;
    int                  k;
    nn[0] = n0;
    nn[1] = n1;
    @(posedge clk); #1;
    e = '{default: 0};
    e.cyc = cyc + LAT;
    for (int ch = 0; ch < NCH; ch++) begin
      k = kind(m_st[ch], nn[ch]);
      if (k == 1) begin e.cw[ch]  = 1'b1; m_pos[ch] = m_pos[ch] + 8'd1; m_dir[ch] = 1'b1; end
      if (k == 2) begin e.ccw[ch] = 1'b1; m_pos[ch] = m_pos[ch] - 8'd1; m_dir[ch] = 1'b0; end
      if (k == 3) e.err[ch] = 1'b1;
      a[ch]    = nn[ch][1];
      b[ch]    = nn[ch][0];
      m_st[ch] = nn[ch];
    end
    if (clr_hit) m_pos[0] = '0;
    e.pos = m_pos;
    e.dir = m_dir;
    if (|{e.cw, e.ccw, e.err}) sbq.push_back(e);
    if (clr_hit) begin
      repeat (LAT - 1) @(posedge clk);
      #1 clr[0] = 1'b1;
      @(posedge clk);
      #1 clr[0] = 1'b0;
    end
    repeat (hold) @(posedge clk);
  endtask

  task automatic clear0();
    @(posedge clk); #1 clr[0] = 1'b1;
    @(posedge clk); #1 clr[0] = 1'b0;
    m_pos[0] = '0;
    repeat (2) @(posedge clk);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (|{cw, ccw, err})) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse actual=cw%b/ccw%b/err%b required=none (cyc=%0d)", cw, ccw, err, cyc);
      end else begin
        e = sbq.pop_front();
        chk("latency", cyc, e.cyc);
        chk("cw", cw, e.cw);
        chk("ccw", ccw, e.ccw);
        chk("err", err, e.err);
        chk("pos", pos, e.pos);
        chk("dir", dir, e.dir);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    a = '0; b = '0; clr = '0;
    m_pos = '0; m_dir = '0; m_st = '0;

    repeat (2) @(posedge clk); #1;
    chk("rst_pulses", {cw, ccw, err}, 0);
    chk("rst_dir", dir, 0);
    chk("rst_pos", pos, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (12) @(posedge clk);

    // four CW steps on ch0
    apply(2'b10, 2'b00, 0, 9);
    apply(2'b11, 2'b00, 0, 9);
    apply(2'b01, 2'b00, 0, 9);
    apply(2'b00, 2'b00, 0, 9);
    #1;
    chk("pos0_after_4cw", pos[0], 4);
    chk("dir0_after_4cw", dir[0], 1);
    chk("pos1_idle", pos[1], 0);
    chk("dir1_idle", dir[1], 0);

    // 2-cycle glitch is filtered; 3-cycle hold is accepted (then returns: ccw)
    @(posedge clk); #1 a[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1 a[0] = 1'b0;
    repeat (12) @(posedge clk);
    chk("pos0_after_glitch", pos[0], 4);
    apply(2'b10, 2'b00, 0, 2);
    apply(2'b00, 2'b00, 0, 9);

    // CCW from zero wraps to all ones
    clear0();
    chk("pos0_clr", pos[0], 0);
    apply(2'b01, 2'b00, 0, 9);
    chk("pos0_wrap_down", pos[0], 8'hFF);
    chk("dir0_ccw", dir[0], 0);

    // illegal jump on ch1
    apply(2'b01, 2'b11, 0, 9);
    chk("pos1_after_err", pos[1], 0);
    chk("dir1_after_err", dir[1], 0);

    // simultaneous steps on both channels; ch0 wraps FF -> 00
    apply(2'b00, 2'b01, 0, 9);

    // walk ch0 to 7, then CW step with clr in the same cycle
    for (int i = 0; i < 7; i++) apply(cw_next(m_st[0]), m_st[1], 0, 9);
    chk("pos0_seven", pos[0], 7);
    apply(cw_next(m_st[0]), m_st[1], 1, 9);
    chk("pos0_clr_wins", pos[0], 0);
    chk("dir0_clr_step", dir[0], 1);

    // reach pos0=5 at state 11, then reset mid-filter
    apply(2'b10, m_st[1], 0, 9);
    clear0();
    for (int i = 0; i < 5; i++) apply(cw_next(m_st[0]), m_st[1], 0, 9);
    chk("state0_11", m_st[0], 2'b11);
    chk("pos0_pre_rst", pos[0], 5);
    @(posedge clk); #1 a[0] = 1'b0;
    m_st[0] = 2'b01;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #2;
    chk("async_rst_pos", pos, 0);
    chk("async_rst_dir", dir, 0);
    chk("async_rst_pulses", {cw, ccw, err}, 0);
    m_pos = '0;
    m_dir = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("pos_after_rst", pos, 0);
    chk("dir_after_rst", dir, 0);

    repeat (5) @(posedge clk);
    chk("sb_drained", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/quad_decoder.md
QUAD_DECODER -- requirements
Module: quad_decoder

Interface
REQ-001 SHALL have parameter NCH, default 4: number of independent quadrature channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 16: position counter width per channel (2..32).
REQ-003 SHALL have parameter FILT_LEN, default 3: consecutive stable cycles required to accept an input level (1..15).
REQ-004 SHALL have port clk, input, 1: single system clock; all state on rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port a, input, NCH: encoder phase A per channel, asynchronous to clk.
REQ-007 SHALL have port b, input, NCH: encoder phase B per channel, asynchronous to clk.
REQ-008 SHALL have port clr, input, NCH: synchronous per-channel position clear.
REQ-009 SHALL have port cw, output, NCH: one-cycle clockwise step pulse.
REQ-010 SHALL have port ccw, output, NCH: one-cycle counterclockwise step pulse.
REQ-011 SHALL have port err, output, NCH: one-cycle illegal-transition pulse.
REQ-012 SHALL have port dir, output, NCH: last valid direction (1 = CW), sticky.
REQ-013 SHALL have port pos, output, NCH x CNT_W: signed two's-complement position per channel.

Function
REQ-014 SHALL pass each a/b bit through a 2-flop synchroniser before any use.
REQ-015 SHALL update a channel's filtered state {a,b} only after the synchronised pair has held one value for FILT_LEN consecutive cycles; shorter glitches are discarded.
REQ-016 SHALL decode filtered-state changes prev->cur as CW: 00->10, 10->11, 11->01, 01->00; CCW: the reverse four; both bits changing is illegal.
REQ-017 SHALL assert cw or ccw for exactly one cycle per accepted step and increment or decrement pos in that same cycle; dir updates in that same cycle.
REQ-018 SHALL, on an illegal transition, assert err for one cycle, leave pos and dir unchanged and assert neither cw nor ccw.
REQ-019 SHALL have a fixed latency of FILT_LEN+3 clk edges from an input change to the cw/ccw/err pulse.
REQ-020 SHALL wrap pos modulo 2^CNT_W (max+1 -> min, 0-1 -> all ones).
REQ-021 SHALL, when clr is high, load pos with 0 on the next edge; clr overrides a same-cycle step for pos, but the cw/ccw pulse and dir update still occur.
REQ-022 SHALL load the first filtered state after reset without generating cw, ccw or err.
REQ-023 SHALL keep channels fully independent; simultaneous events on different channels are all reported in the same cycle.

Reset
REQ-024 SHALL, while rst_n is low, force cw, ccw, err, dir and pos to 0, and clear synchronisers, filters and the first-sample flag, regardless of clk.
REQ-025 SHALL abandon any in-progress filter count when reset is asserted mid-operation; no pulse is emitted for it after release.

Configuration
REQ-026 SHALL, when QDEC_INDEX_EN is defined, add input z (NCH bits), synchronised with 2 flops and unfiltered, whose rising edge clears pos exactly like clr.
REQ-027 SHALL, when QDEC_INDEX_EN is undefined, have no z port and no index logic.

Structure
REQ-028 SHALL place the 2-bit quadrature state typedef, the step enum (NONE, CW, CCW, ERR) and the transition-decode function in package quad_decoder_pkg.
REQ-029 SHALL implement one channel (sync, filter, decode, counter) as sub-module quad_channel, instantiated NCH times by generate.

Verification (NCH=2, CNT_W=8, FILT_LEN=3)
REQ-030 SHALL cover: ch0 steps 00->10->11->01->00, each held 10 cycles -> 4 cw pulses, pos0 = 4, dir0 = 1, ch1 outputs stay 0.
REQ-031 SHALL cover: from pos0 = 0, one CCW step 00->01 -> ccw pulse, pos0 = 8'hFF, dir0 = 0.
REQ-032 SHALL cover: a held high 2 cycles then low -> no pulse, pos unchanged; the same input held 3 cycles -> exactly one cw pulse.
REQ-033 SHALL cover: ch1 jumps 00->11 -> err1 high for 1 cycle, pos1, cw1, ccw1 and dir1 unchanged.
REQ-034 SHALL cover: clr0 high in the same cycle as a CW step with pos0 = 7 -> cw0 pulse, pos0 = 0 next cycle.
REQ-035 SHALL cover: rst_n low mid-run with pos0 = 5 and inputs at 11, then released -> all outputs 0, no pulse or err after release, pos0 = 0.
